step_dir_decoder: RTL and testbench

Receive-side counterpart of the motion core's step/dir generator. Takes asynchronous step/dir lines from an external controller or a loopback of our own generator outputs and turns them into a signed position count, a step-interval measurement and protocol-error flags. It sits between the board input pins and the motion register bank. Uses the same direction convention as the generator: dir=1 is forward (+1), dir=0 is reverse (−1).

---
 rtl/motion_pkg.sv | 12 +
 rtl/step_dir_decoder_if.sv | 39 +++
 rtl/sync_glitch_filter.sv | 59 +++++
 rtl/step_dir_decoder.sv | 173 +++++++++++++++++
 tb/tb_step_dir_decoder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: definitions shared by the motion core's step/dir generator and decoder.
//   DEF_POS_W / DEF_PER_W : default position and interval counter widths
//   DIR_FWD / DIR_REV     : level on the dir line for forward (+1) and reverse (-1) motion
package motion_pkg;

   localparam int unsigned DEF_POS_W = 32;
   localparam int unsigned DEF_PER_W = 24;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

endpackage : motion_pkg

// File: rtl/step_dir_decoder_if.sv
// step_dir_decoder_if: pin-side and register-side signals of the step/dir decoder.
//   Inputs to the decoder : step_in, dir_in (asynchronous lines), clear, load_pos, pos_val,
//                           setup_min
//   Outputs of the decoder: pos, dir_q, step_seen, period, period_valid, stalled, setup_err
//   modport master : drives the inputs, observes the outputs (board / register bank side)
//   modport slave  : the decoder itself
interface step_dir_decoder_if
   import motion_pkg::*;
#(
   parameter int unsigned POS_W = DEF_POS_W,
   parameter int unsigned PER_W = DEF_PER_W
);

   logic             step_in;
   logic             dir_in;
   logic             clear;
   logic             load_pos;
   logic [POS_W-1:0] pos_val;
   logic [7:0]       setup_min;

   logic [POS_W-1:0] pos;
   logic             dir_q;
   logic             step_seen;
   logic [PER_W-1:0] period;
   logic             period_valid;
   logic             stalled;
   logic             setup_err;

   modport master (
      output step_in, dir_in, clear, load_pos, pos_val, setup_min,
      input  pos, dir_q, step_seen, period, period_valid, stalled, setup_err
   );

   modport slave (
      input  step_in, dir_in, clear, load_pos, pos_val, setup_min,
      output pos, dir_q, step_seen, period, period_valid, stalled, setup_err
   );

endinterface : step_dir_decoder_if

// File: rtl/sync_glitch_filter.sv
// sync_glitch_filter: synchronizes one asynchronous line and removes short pulses.
//   clk     : clock
//   reset   : synchronous, active-high; clears the synchronizer and the filtered level
//   i_in    : asynchronous input line
//   o_level : filtered level; follows i_in only after the synchronized value has differed
//             from it for FILTER_LEN consecutive cycles
// SYNC_STAGES must be >= 2, FILTER_LEN must be >= 1.
module sync_glitch_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_in,
   output logic o_level
);

   localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level;
   logic [CNT_W-1:0]       r_cnt;

   logic                   w_sync;
   logic                   w_level_d;
   logic [CNT_W-1:0]       w_cnt_d;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // The counter only runs while the synchronized input disagrees with the accepted level;
   // any agreement restarts it, so a pulse must be FILTER_LEN cycles wide to get through.
   always_comb begin
      w_level_d = r_level;
      w_cnt_d   = '0;
      if (w_sync != r_level) begin
         if (r_cnt == CNT_LAST) begin
            w_level_d = w_sync;
         end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_in};
         r_level <= w_level_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign o_level = r_level;

endmodule : sync_glitch_filter

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: turns asynchronous step/dir lines into a signed position count, a
// step-interval measurement and a direction setup-violation flag.
//   clk    : clock
//   reset  : synchronous, active-high
//   io_bus : step_dir_decoder_if slave modport
//            step_in/dir_in  asynchronous lines (rising step edge = one step, dir=1 forward)
//            clear           zero pos, period, interval and flags; re-arm first-step state
//            load_pos        pos <= pos_val (wins over a coincident step increment)
//            setup_min       required filtered-dir stable cycles before a step (0 = off)
//            pos             signed step count, wraps silently
//            dir_q           filtered direction
//            step_seen       one-cycle pulse per accepted step
//            period          cycles between the last two accepted steps
//            period_valid    period is a real measurement
//            stalled         interval counter saturated since the last step
//            setup_err       sticky: a step arrived too soon after a dir change
module step_dir_decoder
   import motion_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned POS_W       = DEF_POS_W,
   parameter int unsigned PER_W       = DEF_PER_W
) (
   input  logic                clk,
   input  logic                reset,
   step_dir_decoder_if.slave   io_bus
);

   localparam logic [PER_W-1:0] IVL_MAX = '1;
   localparam logic [7:0]       AGE_MAX = 8'hFF;

   logic w_step_lvl;
   logic w_dir_lvl;

   sync_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_step_filt (
      .clk     (clk),
      .reset   (reset),
      .i_in    (io_bus.step_in),
      .o_level (w_step_lvl)
   );

   sync_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_dir_filt (
      .clk     (clk),
      .reset   (reset),
      .i_in    (io_bus.dir_in),
      .o_level (w_dir_lvl)
   );

   logic             r_step_prev;
   logic             r_dir_prev;
   logic [7:0]       r_dir_age;
   logic [POS_W-1:0] r_pos;
   logic [PER_W-1:0] r_ivl;
   logic [PER_W-1:0] r_period;
   logic             r_period_valid;
   logic             r_stalled;
   logic             r_setup_err;
   logic             r_step_seen;
   logic             r_first;

   logic             w_rise;
   logic             w_dir_chg;
   logic [7:0]       w_dir_age_d;
   logic             w_ivl_sat;
   logic [POS_W-1:0] w_pos_d;
   logic [PER_W-1:0] w_ivl_d;
   logic [PER_W-1:0] w_period_d;
   logic             w_period_valid_d;
   logic             w_stalled_d;
   logic             w_setup_err_d;
   logic             w_step_seen_d;
   logic             w_first_d;

   assign w_rise    = w_step_lvl & ~r_step_prev;
   assign w_dir_chg = w_dir_lvl ^ r_dir_prev;
   assign w_ivl_sat = (r_ivl == IVL_MAX);

   // Age as of this cycle: 0 when the filtered dir changes now, so a step arriving d cycles
   // after a dir change is checked against d.
   always_comb begin
      w_dir_age_d = r_dir_age;
      if (w_dir_chg) begin
         w_dir_age_d = '0;
      end else if (r_dir_age != AGE_MAX) begin
         w_dir_age_d = r_dir_age + 8'd1;
      end
   end

   always_comb begin
      w_pos_d          = r_pos;
      w_ivl_d          = w_ivl_sat ? r_ivl : r_ivl + PER_W'(1);
      w_period_d       = r_period;
      w_period_valid_d = r_period_valid;
      w_stalled_d      = r_stalled;
      w_setup_err_d    = r_setup_err;
      w_step_seen_d    = 1'b0;
      w_first_d        = r_first;

      if (io_bus.clear) begin
         // A coincident step is dropped entirely.
         w_pos_d          = '0;
         w_ivl_d          = '0;
         w_period_d       = '0;
         w_period_valid_d = 1'b0;
         w_stalled_d      = 1'b0;
         w_setup_err_d    = 1'b0;
         w_first_d        = 1'b1;
      end else begin
         if (w_rise) begin
            w_step_seen_d    = 1'b1;
            w_period_d       = r_ivl;
            w_ivl_d          = PER_W'(1);
            w_period_valid_d = ~r_first & ~w_ivl_sat;
            w_stalled_d      = 1'b0;
            w_first_d        = 1'b0;
            if (w_dir_age_d < io_bus.setup_min) begin
               w_setup_err_d = 1'b1;
            end
            w_pos_d = (w_dir_lvl == DIR_FWD) ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
         end else if (w_ivl_d == IVL_MAX) begin
            w_stalled_d      = 1'b1;
            w_period_valid_d = 1'b0;
         end
         if (io_bus.load_pos) begin
            w_pos_d = io_bus.pos_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_step_prev    <= 1'b0;
         r_dir_prev     <= 1'b0;
         r_dir_age      <= '0;
         r_pos          <= '0;
         r_ivl          <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_stalled      <= 1'b0;
         r_setup_err    <= 1'b0;
         r_step_seen    <= 1'b0;
         r_first        <= 1'b1;
      end else begin
         r_step_prev    <= w_step_lvl;
         r_dir_prev     <= w_dir_lvl;
         r_dir_age      <= w_dir_age_d;
         r_pos          <= w_pos_d;
         r_ivl          <= w_ivl_d;
         r_period       <= w_period_d;
         r_period_valid <= w_period_valid_d;
         r_stalled      <= w_stalled_d;
         r_setup_err    <= w_setup_err_d;
         r_step_seen    <= w_step_seen_d;
         r_first        <= w_first_d;
      end
   end

   assign io_bus.pos          = r_pos;
   assign io_bus.dir_q        = w_dir_lvl;
   assign io_bus.step_seen    = r_step_seen;
   assign io_bus.period       = r_period;
   assign io_bus.period_valid = r_period_valid;
   assign io_bus.stalled      = r_stalled;
   assign io_bus.setup_err    = r_setup_err;

endmodule : step_dir_decoder

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed bench for step_dir_decoder. A default-width instance and an
// 8-bit-interval instance see the same stimulus; the narrow one exercises the stall path.
module tb_step_dir_decoder;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errs;
   int   seen_cnt;
   int   seen_base;

   step_dir_decoder_if                u_if ();
   step_dir_decoder_if #(.PER_W (8))  u_if8 ();

   assign u_if8.step_in   = u_if.step_in;
   assign u_if8.dir_in    = u_if.dir_in;
   assign u_if8.clear     = u_if.clear;
   assign u_if8.load_pos  = u_if.load_pos;
   assign u_if8.pos_val   = u_if.pos_val;
   assign u_if8.setup_min = u_if.setup_min;

   step_dir_decoder u_dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (u_if.slave)
   );

   step_dir_decoder #(.PER_W (8)) u_dut8 (
      .clk    (clk),
      .reset  (reset),
      .io_bus (u_if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (u_if.step_seen) seen_cnt <= seen_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      u_if.step_in = 1'b1;
      repeat (hi) tick();
      u_if.step_in = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pos"},   64'(u_if.pos), 64'd0);
      check({tag, "_dir"},   64'(u_if.dir_q), 64'd0);
      check({tag, "_seen"},  64'(u_if.step_seen), 64'd0);
      check({tag, "_per"},   64'(u_if.period), 64'd0);
      check({tag, "_pv"},    64'(u_if.period_valid), 64'd0);
      check({tag, "_stall"}, 64'(u_if.stalled), 64'd0);
      check({tag, "_serr"},  64'(u_if.setup_err), 64'd0);
   endtask

   initial begin
      n_checks       = 0;
      n_errs         = 0;
      seen_cnt       = 0;
      reset          = 1'b1;
      u_if.step_in   = 1'b0;
      u_if.dir_in    = 1'b0;
      u_if.clear     = 1'b0;
      u_if.load_pos  = 1'b0;
      u_if.pos_val   = '0;
      u_if.setup_min = 8'd0;
      repeat (3) tick();
      check_reset_state("rst");
      reset = 1'b0;

      u_if.dir_in = 1'b1;
      repeat (10) tick();
      check("dir_fwd", 64'(u_if.dir_q), 64'd1);

      // Latency and basic counting: 10 pulses, 8 high / 20 low.
      seen_base    = seen_cnt;
      u_if.step_in = 1'b1;
      repeat (6) tick();
      check("lat_early", 64'(u_if.step_seen), 64'd0);
      tick();
      check("lat_seen", 64'(u_if.step_seen), 64'd1);
      check("lat_pos", 64'(u_if.pos), 64'd1);
      tick();
      check("seen_width", 64'(u_if.step_seen), 64'd0);
      u_if.step_in = 1'b0;
      repeat (20) tick();
      check("pv_first", 64'(u_if.period_valid), 64'd0);
      pulse(8, 20);
      check("per_2nd", 64'(u_if.period), 64'd28);
      check("pv_2nd", 64'(u_if.period_valid), 64'd1);
      repeat (8) pulse(8, 20);
      check("pos_10", 64'(u_if.pos), 64'd10);
      check("seen_10", 64'(seen_cnt - seen_base), 64'd10);
      check("per_28", 64'(u_if.period), 64'd28);

      // Glitch filter boundary.
      seen_base = seen_cnt;
      pulse(3, 20);
      check("glitch3_pos", 64'(u_if.pos), 64'd10);
      check("glitch3_seen", 64'(seen_cnt - seen_base), 64'd0);
      pulse(4, 20);
      check("pulse4_pos", 64'(u_if.pos), 64'd11);
      check("pulse4_seen", 64'(seen_cnt - seen_base), 64'd1);

      // Direction reversal with only 2 cycles of setup.
      u_if.setup_min = 8'd5;
      u_if.dir_in    = 1'b0;
      repeat (2) tick();
      pulse(8, 20);
      check("rev_pos", 64'(u_if.pos), 64'd10);
      check("rev_dir", 64'(u_if.dir_q), 64'd0);
      check("serr_set", 64'(u_if.setup_err), 64'd1);
      u_if.clear = 1'b1;
      tick();
      u_if.clear = 1'b0;
      check("clr_serr", 64'(u_if.setup_err), 64'd0);
      check("clr_pos", 64'(u_if.pos), 64'd0);
      check("clr_per", 64'(u_if.period), 64'd0);
      check("clr_pv", 64'(u_if.period_valid), 64'd0);
      u_if.dir_in = 1'b1;
      repeat (6) tick();
      pulse(8, 20);
      check("setup6_serr", 64'(u_if.setup_err), 64'd0);
      check("setup6_pos", 64'(u_if.pos), 64'd1);
      check("clr_first_pv", 64'(u_if.period_valid), 64'd0);
      u_if.setup_min = 8'd0;

      // Stall on the 8-bit interval instance.
      pulse(8, 20);
      repeat (200) tick();
      check("stall_early", 64'(u_if8.stalled), 64'd0);
      repeat (60) tick();
      check("stall_set", 64'(u_if8.stalled), 64'd1);
      check("stall_pv", 64'(u_if8.period_valid), 64'd0);
      check("wide_no_stall", 64'(u_if.stalled), 64'd0);
      pulse(8, 22);
      check("stall_clr", 64'(u_if8.stalled), 64'd0);
      check("stall_step_pv", 64'(u_if8.period_valid), 64'd0);
      pulse(8, 22);
      check("per_30", 64'(u_if8.period), 64'd30);
      check("pv_30", 64'(u_if8.period_valid), 64'd1);

      // load_pos coinciding with an accepted step.
      u_if.step_in = 1'b1;
      repeat (6) tick();
      u_if.load_pos = 1'b1;
      u_if.pos_val  = 32'd1000;
      tick();
      u_if.load_pos = 1'b0;
      check("ld_seen", 64'(u_if.step_seen), 64'd1);
      check("ld_pos", 64'(u_if.pos), 64'd1000);
      tick();
      u_if.step_in = 1'b0;
      repeat (20) tick();
      check("ld_hold", 64'(u_if.pos), 64'd1000);

      // Wrap at the positive limit.
      u_if.load_pos = 1'b1;
      u_if.pos_val  = 32'h7FFF_FFFF;
      tick();
      u_if.load_pos = 1'b0;
      check("ld_max", 64'(u_if.pos), 64'h7FFF_FFFF);
      pulse(8, 20);
      check("wrap", 64'(u_if.pos), 64'h8000_0000);

      // Reset asserted while step_in is high.
      u_if.load_pos = 1'b1;
      u_if.pos_val  = 32'd50;
      tick();
      u_if.load_pos = 1'b0;
      check("ld_50", 64'(u_if.pos), 64'd50);
      u_if.step_in = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check_reset_state("midrst");
      reset     = 1'b0;
      seen_base = seen_cnt;
      repeat (10) tick();
      u_if.step_in = 1'b0;
      repeat (20) tick();
      check("midrst_seen", 64'(seen_cnt - seen_base), 64'd1);
      check("midrst_pos1", 64'(u_if.pos), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule : tb_step_dir_decoder
